// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner
// Time-multiplexed scanner for a common-anode multi-digit seven-segment display.
// Each digit gets a slot of REFRESH_DIV clocks. The first BLANK_CYCLES clocks
// of every slot keep all anodes dark so segment lines settle without ghosting.
// During the rest of the slot the anode is PWM-gated by a live brightness value.
// digits/dps/digit_en are snapshotted once per frame, on the first cycle of the
// leftmost slot, together with the leading-zero suppression mask derived from
// them. Nothing the datapath does mid-frame is visible until the next frame.
// Parameter constraints:
//   NUM_DIGITS >= 2
//   0 < BLANK_CYCLES < REFRESH_DIV
//   REFRESH_DIV >= 2**BRIGHT_WIDTH
module seven_segment_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 131072,
    parameter int BLANK_CYCLES = 1024,
    parameter int BRIGHT_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   digits,
    input  logic [NUM_DIGITS-1:0]     dps,
    input  logic [NUM_DIGITS-1:0]     digit_en,
    input  logic                      lz_suppress,
    input  logic [BRIGHT_WIDTH-1:0]   brightness,
    output logic [3:0]                data_out,
    output logic                      dp_out,
    output logic [NUM_DIGITS-1:0]     anode,
    output logic                      frame_start
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LEFT  = IDX_W'(NUM_DIGITS - 1);

    // Scan position
    logic [CNT_W-1:0]        slot_cnt_q, slot_cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;

    // Frame snapshot; the suppression mask stands in for the latched lz flag
    logic [4*NUM_DIGITS-1:0] snap_digits_q, snap_digits_d;
    logic [NUM_DIGITS-1:0]   snap_dps_q, snap_dps_d;
    logic [NUM_DIGITS-1:0]   snap_en_q, snap_en_d;
    logic [NUM_DIGITS-1:0]   snap_sup_q, snap_sup_d;

    // Registered outputs
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic [3:0]              data_out_q, data_out_d;
    logic                    dp_out_q, dp_out_d;
    logic                    frame_start_q, frame_start_d;

    // Intermediate decode
    logic                    slot_last;
    logic                    capture;
    logic [NUM_DIGITS-1:0]   sup_in;
    logic                    blank_above;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_en;
    logic                    cur_sup;
    logic                    bright_ok;
    logic                    lit;

    assign slot_last = (slot_cnt_q == SLOT_LAST);
    assign capture   = (slot_cnt_q == '0) && (idx_q == IDX_LEFT);

    // Slot counter and digit index: scan from leftmost (highest) to rightmost
    always_comb begin
        slot_cnt_d = slot_last ? '0 : slot_cnt_q + CNT_W'(1);
        idx_d      = idx_q;
        if (slot_last) begin
            idx_d = (idx_q == '0) ? IDX_LEFT : idx_q - IDX_W'(1);
        end
    end

    // Leading-zero mask from the live inputs. A digit blanks only while every
    // digit to its left is itself blanked or disabled; digit 0 always shows.
    always_comb begin
        sup_in      = '0;
        blank_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            sup_in[i]   = lz_suppress && (digits[4*i +: 4] == 4'h0)
                          && !dps[i] && blank_above;
            blank_above = blank_above && (sup_in[i] || !digit_en[i]);
        end
    end

    // Snapshot next-state; on the capture cycle the fresh values also feed
    // the output decode so the first slot of a frame already shows new data
    always_comb begin
        snap_digits_d = snap_digits_q;
        snap_dps_d    = snap_dps_q;
        snap_en_d     = snap_en_q;
        snap_sup_d    = snap_sup_q;
        if (capture) begin
            snap_digits_d = digits;
            snap_dps_d    = dps;
            snap_en_d     = digit_en;
            snap_sup_d    = sup_in;
        end
    end

    // Select the active digit's snapshot fields
    always_comb begin
        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        cur_en  = 1'b0;
        cur_sup = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib = snap_digits_d[4*i +: 4];
                cur_dp  = snap_dps_d[i];
                cur_en  = snap_en_d[i];
                cur_sup = snap_sup_d[i];
            end
        end
    end

    // Lit decision: past the blanking window, digit shown, PWM phase on
    always_comb begin
        bright_ok = (&brightness) || (slot_cnt_q[BRIGHT_WIDTH-1:0] < brightness);
        lit       = (slot_cnt_q >= BLANK_END) && cur_en && !cur_sup && bright_ok;
    end

    // Output next-state: at most one anode low, and only while lit
    always_comb begin
        anode_d = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                anode_d[i] = !lit;
            end
        end
        data_out_d    = cur_nib;
        dp_out_d      = !(cur_dp && lit);
        frame_start_d = capture;
    end

    // State and output registers; reset darkens the display on the next edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_cnt_q    <= '0;
            idx_q         <= IDX_LEFT;
            snap_digits_q <= '0;
            snap_dps_q    <= '0;
            snap_en_q     <= '0;
            snap_sup_q    <= '0;
            anode_q       <= '1;
            data_out_q    <= 4'h0;
            dp_out_q      <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            slot_cnt_q    <= slot_cnt_d;
            idx_q         <= idx_d;
            snap_digits_q <= snap_digits_d;
            snap_dps_q    <= snap_dps_d;
            snap_en_q     <= snap_en_d;
            snap_sup_q    <= snap_sup_d;
            anode_q       <= anode_d;
            data_out_q    <= data_out_d;
            dp_out_q      <= dp_out_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign anode       = anode_q;
    assign data_out    = data_out_q;
    assign dp_out      = dp_out_q;
    assign frame_start = frame_start_q;

endmodule
